// File: rtl/key_step_pkg.sv
// Shared types and helpers for the key/step debounce front end.
// Used by key_step_debounce; see that file for the KEY_STEP_REPEAT_EN option.
package key_step_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRESS_CHK = 2'd1,
        HELD      = 2'd2,
        REL_CHK   = 2'd3
    } key_state_t;

    // Counter width large enough to hold the largest reload value.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for one asynchronous bit, with a selectable reset value.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/key_step_debounce.sv
// Debounces an active-low key into one-cycle step pulses with a captured w sample.
// Optional auto-repeat while held is enabled by defining KEY_STEP_REPEAT_EN.
module key_step_debounce
    import key_step_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 10000000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       key_n,
    input  logic       w_in,
    output logic       step,
    output logic       w_out,
    output logic       held,
    output key_state_t dbg_state
);

    localparam int CW = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
    localparam logic [CW-1:0] DEB_LOAD = CW'(DEBOUNCE_CYCLES - 1);
`ifdef KEY_STEP_REPEAT_EN
    localparam logic [CW-1:0] REP_DELAY_LOAD  = CW'(REPEAT_DELAY - 1);
    localparam logic [CW-1:0] REP_PERIOD_LOAD = CW'(REPEAT_PERIOD - 1);
`endif

    logic          key_s;
    logic          w_s;
    key_state_t    state;
    key_state_t    state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          step_nxt;
    logic          w_out_nxt;

    // Key idles high (released), so its synchroniser resets to 1.
    sync_2ff #(.RESET_VAL(1'b1)) u_key_sync (
        .clock (clock),
        .reset (reset),
        .d     (key_n),
        .q     (key_s)
    );

    sync_2ff #(.RESET_VAL(1'b0)) u_w_sync (
        .clock (clock),
        .reset (reset),
        .d     (w_in),
        .q     (w_s)
    );

    // step is a one-cycle strobe with no back-pressure; w_out is valid on the
    // step cycle and holds until the next step.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        step_nxt  = 1'b0;
        w_out_nxt = w_out;
        case (state)
            IDLE: begin
                if (!key_s) begin
                    state_nxt = PRESS_CHK;
                    cnt_nxt   = DEB_LOAD;
                end
            end
            PRESS_CHK: begin
                if (key_s) begin
                    state_nxt = IDLE;
                end else if (cnt != '0) begin
                    cnt_nxt = cnt - CW'(1);
                end else begin
                    state_nxt = HELD;
                    step_nxt  = 1'b1;
                    w_out_nxt = w_s;
`ifdef KEY_STEP_REPEAT_EN
                    cnt_nxt   = REP_DELAY_LOAD;
`endif
                end
            end
            HELD: begin
                if (key_s) begin
                    state_nxt = REL_CHK;
                    cnt_nxt   = DEB_LOAD;
                end
`ifdef KEY_STEP_REPEAT_EN
                else if (cnt != '0) begin
                    cnt_nxt = cnt - CW'(1);
                end else begin
                    step_nxt  = 1'b1;
                    w_out_nxt = w_s;
                    cnt_nxt   = REP_PERIOD_LOAD;
                end
`endif
            end
            REL_CHK: begin
                if (!key_s) begin
                    state_nxt = HELD;
`ifdef KEY_STEP_REPEAT_EN
                    cnt_nxt   = REP_PERIOD_LOAD;
`endif
                end else if (cnt != '0) begin
                    cnt_nxt = cnt - CW'(1);
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
            step  <= 1'b0;
            w_out <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            step  <= step_nxt;
            w_out <= w_out_nxt;
        end
    end

    assign held      = (state == HELD) || (state == REL_CHK);
    assign dbg_state = state;

endmodule

// File: tb/tb_key_step_debounce.sv
// Bench for key_step_debounce: random key/w stimulus against a run-length model.
// Builds with or without KEY_STEP_REPEAT_EN; the model follows the same define.
module tb_key_step_debounce;

  localparam int D  = 4;
  localparam int RD = 10;
  localparam int RP = 3;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       key_n = 1'b1;
  logic       w_in  = 1'b0;
  logic       step;
  logic       w_out;
  logic       held;
  logic [1:0] dbg_state;

  key_step_debounce #(
    .DEBOUNCE_CYCLES (D),
    .REPEAT_DELAY    (RD),
    .REPEAT_PERIOD   (RP)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .key_n     (key_n),
    .w_in      (w_in),
    .step      (step),
    .w_out     (w_out),
    .held      (held),
    .dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  initial forever #5 clock = ~clock;

  // ---------------- scoreboard state ----------------
  int n_total = 0;
  int n_bad   = 0;
  logic [32:0] exp_q[$];   // {edge number, expected w_out}

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, req);
    end
  endtask

  // ---------------- reference model ----------------
  // The key is accepted (pressed or released) once D+1 consecutive synchronised
  // samples agree; the synchroniser is a plain two-sample delay line.
  int   cyc       = 0;
  logic m_k1      = 1'b1;
  logic m_k2      = 1'b1;
  logic m_w1      = 1'b0;
  logic m_w2      = 1'b0;
  logic last_s    = 1'b1;
  int   run       = 0;
  bit   m_pressed = 1'b0;
  logic m_wout    = 1'b0;
  bit   armed     = 1'b0;
  int   next_rep  = 0;

  initial forever begin
    logic s;
    logic ws;
    @(posedge clock or negedge reset);
    if (!reset) begin
      m_k1 = 1'b1; m_k2 = 1'b1; m_w1 = 1'b0; m_w2 = 1'b0;
      last_s = 1'b1; run = 0; m_pressed = 1'b0; m_wout = 1'b0;
      armed = 1'b0; next_rep = 0;
      exp_q.delete();
    end else begin
      cyc++;
      s  = m_k2;
      ws = m_w2;
      m_k2 = m_k1; m_k1 = key_n;
      m_w2 = m_w1; m_w1 = w_in;
      run    = (s == last_s) ? run + 1 : 1;
      last_s = s;
      if (!m_pressed) begin
        if (s == 1'b0 && run == D + 1) begin
          m_pressed = 1'b1;
          m_wout    = ws;
          exp_q.push_back({32'(cyc), ws});
          armed    = 1'b1;
          next_rep = cyc + RD;
        end
      end else if (s == 1'b1) begin
        armed = 1'b0;
        if (run == D + 1) m_pressed = 1'b0;
      end else begin
`ifdef KEY_STEP_REPEAT_EN
        if (!armed) begin
          armed    = 1'b1;
          next_rep = cyc + RP;
        end else if (cyc == next_rep) begin
          m_wout = ws;
          exp_q.push_back({32'(cyc), ws});
          next_rep = cyc + RP;
        end
`endif
      end
    end
  end

  // ---------------- monitor ----------------
  logic prev_step = 1'b0;

  initial forever begin
    logic [32:0] e;
    @(negedge clock);
    chk("held", held, m_pressed);
    chk("w_out", w_out, m_wout);
    if (step) begin
      if (exp_q.size() == 0) begin
        n_total++;
        n_bad++;
        $display("FAIL step_unexpected cycle=%0d actual=1 required=0", cyc);
      end else begin
        e = exp_q.pop_front();
        chk("step_cycle", cyc, e[32:1]);
        chk("step_w", w_out, e[0]);
      end
      chk("step_gap", prev_step, 1'b0);
    end else if (exp_q.size() != 0) begin
      e = exp_q[0];
      if (int'(e[32:1]) <= cyc) begin
        void'(exp_q.pop_front());
        n_total++;
        n_bad++;
        $display("FAIL step_missing cycle=%0d actual=0 required=1", e[32:1]);
      end
    end
    prev_step = step;
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic k, input int n);
    key_n = k;
    repeat (n) @(negedge clock);
  endtask

  task automatic do_reset(input int n);
    @(negedge clock);
    #2 reset = 1'b0;
    #1;
    chk("rst_step", step, 1'b0);
    chk("rst_held", held, 1'b0);
    chk("rst_wout", w_out, 1'b0);
    chk("rst_state", dbg_state, 2'd0);
    repeat (n) @(negedge clock);
    reset = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int len;
    repeat (3) @(negedge clock);
    chk("init_step", step, 1'b0);
    chk("init_held", held, 1'b0);
    chk("init_wout", w_out, 1'b0);
    reset = 1'b1;
    drive(1'b1, 3);

    // clean press with w=1, toggle w while held, release
    w_in = 1'b1;
    drive(1'b0, 12);
    w_in = 1'b0;
    drive(1'b0, 8);
    drive(1'b1, 12);

    // press bounce
    drive(1'b0, 3); drive(1'b1, 1); drive(1'b0, 3); drive(1'b1, 10);

    // w=0 press, then release bounce while held
    drive(1'b0, 10);
    drive(1'b1, 2);
    drive(1'b0, 8);
    drive(1'b1, 12);

    // capture w=1, release, then reset in the middle of the next press check
    w_in = 1'b1;
    drive(1'b0, 10);
    drive(1'b1, 12);
    drive(1'b0, 3);
    do_reset(2);
    drive(1'b0, 12);
    drive(1'b1, 12);

    // long hold (auto-repeat when enabled)
    drive(1'b0, 30);
    drive(1'b1, 12);

    // randomized segments with occasional resets
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 39) == 0) do_reset($urandom_range(1, 3));
      key_n = 1'($urandom_range(0, 1));
      len = ($urandom_range(0, 7) == 0) ? $urandom_range(12, 30) : $urandom_range(1, 9);
      for (int j = 0; j < len; j++) begin
        if ($urandom_range(0, 3) == 0) w_in = ~w_in;
        @(negedge clock);
      end
    end

    drive(1'b1, 15);
    chk("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
